// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode.
// Circular FIFO of {PC, instr} entries with a registered occupancy count.
// Handshakes: a transfer happens on a rising clk edge when valid and ready
// are both 1 on that side; ready/valid never depend on the other side's
// handshake inputs, so there is no combinational path through the queue.
module instr_queue #(
    parameter int DBITS = 32,
    parameter int DEPTH = 4,
    parameter int CBITS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] pcIn,
    input  logic [31:0]      instrIn,
    input  logic             inValid,
    output logic             inReady,
    input  logic             flush,
    output logic [DBITS-1:0] outPc,
    output logic [31:0]      outInstr,
    output logic             outValid,
    input  logic             outReady,
    output logic [CBITS-1:0] count
);

    localparam int PBITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CBITS-1:0] FULL_COUNT = CBITS'(DEPTH);

    // Storage is intentionally left unreset; pointers and count define validity.
    logic [DBITS-1:0] pc_mem_q    [DEPTH];
    logic [31:0]      instr_mem_q [DEPTH];

    logic [PBITS-1:0] wp_q, wp_d;
    logic [PBITS-1:0] rp_q, rp_d;
    logic [CBITS-1:0] count_q, count_d;

    logic push;
    logic pop;

    // Handshake qualifiers derived from registered state only (plus reset).
    always_comb begin
        inReady  = reset && (count_q < FULL_COUNT);
        outValid = (count_q != '0);
        push     = inValid && inReady;
        pop      = outValid && outReady;
        count    = count_q;
        outPc    = outValid ? pc_mem_q[rp_q] : '0;
        outInstr = outValid ? instr_mem_q[rp_q] : '0;
    end

    // Next-state for pointers and count; flush drops any same-cycle push/pop.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push) wp_d = wp_q + 1'b1;
            if (pop)  rp_d = rp_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    // Pointer/count registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Entry write on an accepted push that is not being flushed away.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem_q[wp_q]    <= pcIn;
            instr_mem_q[wp_q] <= instrIn;
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue with DEPTH=4, DBITS=32.
module tb_instr_queue;

  logic        clk;
  logic        reset;
  logic [31:0] pcIn;
  logic [31:0] instrIn;
  logic        inValid;
  logic        inReady;
  logic        flush;
  logic [31:0] outPc;
  logic [31:0] outInstr;
  logic        outValid;
  logic        outReady;
  logic [2:0]  count;

  int checks;
  int failures;

  instr_queue #(.DBITS(32), .DEPTH(4), .CBITS(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .pcIn     (pcIn),
    .instrIn  (instrIn),
    .inValid  (inValid),
    .inReady  (inReady),
    .flush    (flush),
    .outPc    (outPc),
    .outInstr (outInstr),
    .outValid (outValid),
    .outReady (outReady),
    .count    (count)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // advance one rising edge, then settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], ~pc[15:0]};
  endfunction

  task automatic push_one(input logic [31:0] pc);
    pcIn    = pc;
    instrIn = instr_of(pc);
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    pcIn     = '0;
    instrIn  = '0;
    inValid  = 1'b0;
    flush    = 1'b0;
    outReady = 1'b0;

    // reset for two cycles
    tick();
    tick();
    check_eq("rst_count", count, 0);
    check_eq("rst_outvalid", outValid, 0);
    check_eq("rst_outpc", outPc, 0);
    check_eq("rst_outinstr", outInstr, 0);
    check_eq("rst_inready", inReady, 0);

    // single entry, accepted on first cycle out of reset
    reset = 1'b1;
    #1;
    check_eq("first_inready", inReady, 1);
    pcIn    = 32'h40;
    instrIn = 32'h1234_5678;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    check_eq("single_valid", outValid, 1);
    check_eq("single_pc", outPc, 32'h40);
    check_eq("single_instr", outInstr, 32'h1234_5678);
    check_eq("single_count", count, 1);

    // fill to full, then a refused fifth push
    push_one(32'h44);
    push_one(32'h48);
    push_one(32'h4C);
    check_eq("full_count", count, 4);
    check_eq("full_inready", inReady, 0);
    pcIn    = 32'h50;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    check_eq("full_refuse_count", count, 4);
    check_eq("full_head_kept", outPc, 32'h40);

    // drain in order
    outReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check_eq("drain_pc", outPc, 32'h40 + 32'(4 * k));
      check_eq("drain_instr", outInstr, (k == 0) ? 32'h1234_5678 : instr_of(32'h40 + 32'(4 * k)));
      tick();
    end
    outReady = 1'b0;
    check_eq("drain_count", count, 0);
    check_eq("drain_valid", outValid, 0);
    check_eq("drain_pc_zero", outPc, 0);

    // streaming push+pop across two pointer wraps
    outReady = 1'b1;
    for (int k = 0; k < 10; k++) begin
      pcIn    = 32'h40 + 32'(4 * k);
      instrIn = instr_of(pcIn);
      inValid = 1'b1;
      if (k > 0) begin
        check_eq("stream_pc", outPc, 32'h40 + 32'(4 * (k - 1)));
        check_eq("stream_instr", outInstr, instr_of(32'h40 + 32'(4 * (k - 1))));
      end
      tick();
      check_eq("stream_count", count, 1);
    end
    inValid = 1'b0;
    check_eq("stream_last_pc", outPc, 32'h64);
    tick();
    outReady = 1'b0;
    check_eq("stream_end_count", count, 0);

    // flush with 3 queued and a push in flight
    push_one(32'h60);
    push_one(32'h64);
    push_one(32'h68);
    check_eq("preflush_count", count, 3);
    flush   = 1'b1;
    pcIn    = 32'h80;
    instrIn = instr_of(32'h80);
    inValid = 1'b1;
    #1;
    check_eq("flush_inready_ungated", inReady, 1);
    check_eq("flush_outvalid_ungated", outValid, 1);
    tick();
    flush   = 1'b0;
    inValid = 1'b0;
    check_eq("flush_count", count, 0);
    check_eq("flush_valid", outValid, 0);
    check_eq("flush_pc_zero", outPc, 0);
    push_one(32'h100);
    check_eq("postflush_head", outPc, 32'h100);
    check_eq("postflush_count", count, 1);

    // two consecutive flush cycles, then push right after
    flush   = 1'b1;
    pcIn    = 32'h180;
    inValid = 1'b1;
    tick();
    check_eq("flush2a_count", count, 0);
    tick();
    check_eq("flush2b_count", count, 0);
    flush   = 1'b0;
    pcIn    = 32'h200;
    instrIn = instr_of(32'h200);
    tick();
    inValid = 1'b0;
    check_eq("after_flush2_head", outPc, 32'h200);
    check_eq("after_flush2_instr", outInstr, instr_of(32'h200));
    check_eq("after_flush2_count", count, 1);

    // full with simultaneous pop: push refused, inReady returns next cycle
    push_one(32'h204);
    push_one(32'h208);
    push_one(32'h20C);
    check_eq("full2_count", count, 4);
    pcIn     = 32'h210;
    inValid  = 1'b1;
    outReady = 1'b1;
    #1;
    check_eq("full2_inready_same", inReady, 0);
    tick();
    inValid  = 1'b0;
    outReady = 1'b0;
    check_eq("full2_count_after", count, 3);
    check_eq("full2_inready_next", inReady, 1);
    check_eq("full2_head", outPc, 32'h204);

    // reset mid-operation with push and pop active
    pcIn     = 32'h300;
    inValid  = 1'b1;
    outReady = 1'b1;
    reset    = 1'b0;
    #1;
    check_eq("midrst_inready_during", inReady, 0);
    tick();
    check_eq("midrst_count", count, 0);
    check_eq("midrst_valid", outValid, 0);
    check_eq("midrst_pc", outPc, 0);
    check_eq("midrst_inready", inReady, 0);
    outReady = 1'b0;
    reset    = 1'b1;
    pcIn     = 32'h400;
    instrIn  = instr_of(32'h400);
    #1;
    check_eq("midrst_release_inready", inReady, 1);
    tick();
    inValid = 1'b0;
    check_eq("midrst_push_head", outPc, 32'h400);
    check_eq("midrst_push_count", count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter DBITS, default 32, giving the PC width.
REQ-002 SHALL have parameter DEPTH, default 4, giving the queue entry count; legal values are powers of two from 2 to 16.
REQ-003 SHALL have parameter CBITS, default 3, giving the count width (log2(DEPTH)+1).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (0 = in reset), sampled on rising clk.
REQ-006 pcIn  input  DBITS  PC of the incoming instruction, from the fetch stage pcOut.
REQ-007 instrIn  input  32  instruction word read from instruction memory at pcIn.
REQ-008 inValid  input  1  pcIn/instrIn hold a valid fetch this cycle.
REQ-009 inReady  output  1  queue accepts a push this cycle.
REQ-010 flush  input  1  redirect (taken branch/jump, same condition as the fetch stage useImm); discard all queued entries.
REQ-011 outPc  output  DBITS  PC of the head entry, for decode.
REQ-012 outInstr  output  32  instruction word of the head entry.
REQ-013 outValid  output  1  head entry is valid.
REQ-014 outReady  input  1  decode consumes the head this cycle.
REQ-015 count  output  CBITS  number of valid entries, 0..DEPTH.

Function
REQ-016 SHALL be a circular FIFO of DEPTH entries, each {PC, instr}, with write pointer wp and read pointer rp of log2(DEPTH) bits and a count register.
REQ-017 Push: occurs when inValid=1 and inReady=1; the entry is written at wp and wp increments modulo DEPTH.
REQ-018 Pop: occurs when outValid=1 and outReady=1; rp increments modulo DEPTH.
REQ-019 inReady SHALL be 1 when reset=1 and count<DEPTH; it is combinational from registered state only and does not depend on outReady.
REQ-020 outValid SHALL be 1 when count!=0; outPc/outInstr SHALL show the entry at rp with no added latency.
REQ-021 When count=0, outPc and outInstr SHALL be driven to 0.
REQ-022 Count update per cycle: push only -> +1; pop only -> -1; push and pop together -> unchanged, with both pointers advancing.
REQ-023 Full (count=DEPTH): inReady=0, so no push occurs. A pop that cycle makes inReady=1 on the next cycle, not the same cycle.
REQ-024 Empty (count=0): outValid=0, so no pop occurs. A push that cycle makes outValid=1 on the next cycle; there is no same-cycle bypass, giving minimum latency from push to visible head of 1 cycle.
REQ-025 Pointer wrap: a write at index DEPTH-1 is followed by a write at index 0, and data order SHALL be preserved across the wrap.
REQ-026 Flush=1 on a rising edge (reset=1): wp, rp and count become 0. Any push or pop in that cycle is discarded and has no effect. outValid=0 the next cycle.
REQ-027 Flush SHALL NOT gate inReady or outValid in the cycle it is asserted. Upstream sees its handshake completed, but the entry is dropped.
REQ-028 Consecutive flush cycles SHALL keep the queue empty. A push in the first cycle after flush deasserts SHALL be accepted normally.
REQ-029 Storage arrays are not reset or cleared. Only pointers, count and the outputs derived from them define visible state.
REQ-030 Priority SHALL be reset > flush > push/pop.

Reset
REQ-031 While reset=0 at a rising edge: wp=0, rp=0, count=0.
REQ-032 Outputs during and after reset: outValid=0, outPc=0, outInstr=0, count=0; inReady=0 while reset=0.
REQ-033 Reset asserted mid-operation SHALL discard all entries in one cycle, regardless of inValid, outReady or flush.
REQ-034 First push SHALL be accepted on the first cycle with reset=1.

Verification
REQ-035 Reset then single entry: reset=0 for 2 cycles, then push PC=0x40, instr=0x12345678 with outReady=0 -> next cycle outValid=1, outPc=0x40, outInstr=0x12345678, count=1.
REQ-036 Fill and backpressure: push PCs 0x40, 0x44, 0x48, 0x4C with outReady=0 -> count=4, inReady=0; a fifth inValid is not accepted. Then pop 4 -> PCs appear in order 0x40..0x4C, then count=0, outValid=0.
REQ-037 Simultaneous push/pop and wrap: stream 10 PCs 0x40+4k with inValid=1 and outReady=1 continuously -> count stays 1 after the first push, outputs in order with no loss or duplication, and pointers wrap twice.
REQ-038 Flush: 3 entries queued, assert flush for 1 cycle while inValid=1 (PC=0x80) -> next cycle count=0, outValid=0, 0x80 dropped. Then push PC=0x100 -> head 0x100.
REQ-039 Reset mid-operation: count=3 with push and pop active, assert reset=0 for 1 cycle -> next cycle count=0, outValid=0, outPc=0, inReady=0 until reset=1.
REQ-040 Full with pop: count=4, outReady=1 and inValid=1 in the same cycle -> push refused, count=3 next cycle, inReady=1 next cycle.
